// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_loader
// Description : Front-panel entry for the ALU harness. Debounces four buttons,
//               shifts switch nibbles into operands/command, snapshots the ALU
//               result and flags, and pages them out on the LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw,
  input  logic [3:0]  btn,
  input  logic [31:0] result,
  input  logic        carryout,
  input  logic        zero,
  input  logic        overflow,
  output logic [31:0] operandA,
  output logic [31:0] operandB,
  output logic [2:0]  command,
  output logic [3:0]  led,
  output logic        valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] LAST_PAGE = 4'd8;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    SETTLE = 2'd1,
    SHOW   = 2'd2
  } state_t;

  logic [3:0] w_press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == CNT_MAX) begin
          db_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= btn[i];
        sync2_q   <= sync1_q;
        db_q      <= db_d;
        db_prev_q <= db_q;
        cnt_q     <= cnt_d;
      end
    end

    assign w_press[i] = db_q & ~db_prev_q;
  end

  state_t      state_q, state_d;
  logic [31:0] operand_a_q, operand_a_d;
  logic [31:0] operand_b_q, operand_b_d;
  logic [2:0]  command_q, command_d;
  logic [3:0]  led_q, led_d;
  logic        valid_q, valid_d;
  logic [3:0]  page_q, page_d;
  logic [31:0] snap_result_q, snap_result_d;
  logic [2:0]  snap_flags_q, snap_flags_d;

  always_comb begin
    state_d       = state_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    command_d     = command_q;
    led_d         = led_q;
    page_d        = page_q;
    snap_result_d = snap_result_q;
    snap_flags_d  = snap_flags_q;

    unique case (state_q)
      ENTRY, SHOW: begin
        // The if/else chain is the press priority: btn0 > btn1 > btn2 > btn3.
        if (w_press[0]) begin
          operand_a_d = {operand_a_q[27:0], sw};
          led_d       = sw;
          state_d     = ENTRY;
        end else if (w_press[1]) begin
          operand_b_d = {operand_b_q[27:0], sw};
          led_d       = sw;
          state_d     = ENTRY;
        end else if (w_press[2]) begin
          command_d   = sw[2:0];
          led_d       = {1'b0, sw[2:0]};
          state_d     = ENTRY;
        end else if (w_press[3]) begin
          if (state_q == ENTRY) begin
            state_d = SETTLE;
          end else begin
            page_d = (page_q == LAST_PAGE) ? 4'd0 : page_q + 4'd1;
          end
        end
      end
      SETTLE: begin
        snap_result_d = result;
        snap_flags_d  = {overflow, carryout, zero};
        page_d        = 4'd0;
        state_d       = SHOW;
      end
      default: state_d = ENTRY;
    endcase

    // While showing, the LEDs track the page selected for the next cycle.
    if (state_d == SHOW) begin
      if (page_d == LAST_PAGE) begin
        led_d = {1'b0, snap_flags_d};
      end else begin
        led_d = snap_result_d[{page_d[2:0], 2'b00} +: 4];
      end
    end
    valid_d = (state_d == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ENTRY;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      command_q     <= '0;
      led_q         <= '0;
      valid_q       <= 1'b0;
      page_q        <= '0;
      snap_result_q <= '0;
      snap_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      command_q     <= command_d;
      led_q         <= led_d;
      valid_q       <= valid_d;
      page_q        <= page_d;
      snap_result_q <= snap_result_d;
      snap_flags_q  <= snap_flags_d;
    end
  end

  assign operandA = operand_a_q;
  assign operandB = operand_b_q;
  assign command  = command_q;
  assign led      = led_q;
  assign valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_loader
// Description : Self-checking bench: vector table, hand-written timing cases,
//               and random presses against a press-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sw;
  logic [3:0]  btn;
  logic [31:0] result;
  logic        carryout;
  logic        zero;
  logic        overflow;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [2:0]  command;
  logic [3:0]  led;
  logic        valid;

  alu_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .result(result),
    .carryout(carryout), .zero(zero), .overflow(overflow),
    .operandA(operandA), .operandB(operandB), .command(command),
    .led(led), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  sw;
    int          hold;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_cmd;
    logic [3:0]  exp_led;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [7];

  // Reference model state, updated once per completed button press.
  logic [31:0] m_a, m_b, m_snap;
  logic [2:0]  m_cmd, m_flags;
  logic [3:0]  m_led;
  logic        m_show;
  int          m_page;

  logic [3:0] pages [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask, input logic [3:0] s, input int hold);
    sw  = s;
    btn = mask;
    repeat (hold) tick();
    btn = 4'b0000;
    repeat (12) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = 4'b0000;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_all(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c, input logic [3:0] l, input logic v);
    chk({tag, ".operandA"}, operandA, a);
    chk({tag, ".operandB"}, operandB, b);
    chk({tag, ".command"},  {29'd0, command}, {29'd0, c});
    chk({tag, ".led"},      {28'd0, led}, {28'd0, l});
    chk({tag, ".valid"},    {31'd0, valid}, {31'd0, v});
  endtask

  function automatic logic [3:0] model_disp(input logic [31:0] snap, input logic [2:0] fl,
                                            input int page);
    if (page == 8) return {1'b0, fl};
    return 4'((snap >> (4 * page)) & 32'hF);
  endfunction

  initial begin
    int idx;
    logic [3:0] s;

    vecs[0] = '{4'b0001, 4'h2, 10, 32'h12,    32'h0, 3'd0, 4'h2, 1'b0};
    vecs[1] = '{4'b0001, 4'h3, 10, 32'h123,   32'h0, 3'd0, 4'h3, 1'b0};
    vecs[2] = '{4'b0001, 4'h4, 10, 32'h1234,  32'h0, 3'd0, 4'h4, 1'b0};
    vecs[3] = '{4'b0010, 4'hA, 3,  32'h1234,  32'h0, 3'd0, 4'h4, 1'b0};
    vecs[4] = '{4'b0010, 4'hA, 10, 32'h1234,  32'hA, 3'd0, 4'hA, 1'b0};
    vecs[5] = '{4'b0100, 4'hE, 10, 32'h1234,  32'hA, 3'd6, 4'h6, 1'b0};
    vecs[6] = '{4'b0011, 4'h5, 10, 32'h12345, 32'hA, 3'd6, 4'h5, 1'b0};

    pages[0] = 4'hF; pages[1] = 4'hE; pages[2] = 4'hE; pages[3] = 4'hB;
    pages[4] = 4'hD; pages[5] = 4'hA; pages[6] = 4'hE; pages[7] = 4'hD;
    pages[8] = 4'h2;

    sw = 4'h0; btn = 4'h0; result = '0; carryout = 1'b0; zero = 1'b0; overflow = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_all("reset", 32'h0, 32'h0, 3'd0, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick();

    // First btn0 press: raw high first sampled at edge 1, operandA lands at edge 7.
    sw  = 4'h1;
    btn = 4'b0001;
    repeat (6) tick();
    chk("latency.before", operandA, 32'h0);
    tick();
    chk("latency.at", operandA, 32'h1);
    repeat (3) tick();
    btn = 4'b0000;
    repeat (12) tick();
    check_all("first_load", 32'h1, 32'h0, 3'd0, 4'h1, 1'b0);

    for (int i = 0; i < 7; i++) begin
      press(vecs[i].btn, vecs[i].sw, vecs[i].hold);
      check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_cmd, vecs[i].exp_led, vecs[i].exp_valid);
    end

    // Execute: press pulse after edge 6, SETTLE at edge 7, snapshot visible at edge 8.
    result = 32'hDEADBEEF; zero = 1'b0; carryout = 1'b1; overflow = 1'b0;
    btn = 4'b1000;
    repeat (7) tick();
    chk("exec.valid_before", {31'd0, valid}, 32'd0);
    tick();
    chk("exec.valid", {31'd0, valid}, 32'd1);
    chk("exec.led_page0", {28'd0, led}, 32'hF);
    repeat (2) tick();
    btn = 4'b0000;
    repeat (12) tick();
    for (int p = 1; p <= 9; p++) begin
      press(4'b1000, 4'h0, 10);
      chk($sformatf("page%0d.led", p % 9), {28'd0, led}, {28'd0, pages[p % 9]});
    end
    result = 32'h12345678;
    repeat (3) tick();
    chk("snapshot_hold.led", {28'd0, led}, 32'hF);
    chk("snapshot_hold.valid", {31'd0, valid}, 32'd1);

    press(4'b0010, 4'h7, 10);
    check_all("show_load", 32'h12345, 32'hA7, 3'd6, 4'h7, 1'b0);

    // Asynchronous reset dropped between edges while showing.
    press(4'b1000, 4'h0, 10);
    chk("show_again.valid", {31'd0, valid}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 32'h0, 32'h0, 3'd0, 4'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    result = 32'hCAFE0123; overflow = 1'b1; carryout = 1'b0; zero = 1'b1;
    press(4'b1000, 4'h0, 10);
    chk("fresh.valid", {31'd0, valid}, 32'd1);
    chk("fresh.led", {28'd0, led}, 32'h3);
    repeat (8) press(4'b1000, 4'h0, 10);
    chk("fresh.flags", {28'd0, led}, 32'h5);

    // Random presses against the press-level model.
    do_reset();
    m_a = '0; m_b = '0; m_cmd = '0; m_led = '0; m_show = 1'b0; m_page = 0;
    m_snap = '0; m_flags = '0;
    for (int it = 0; it < 40; it++) begin
      idx = int'($urandom_range(0, 3));
      s   = 4'($urandom);
      result   = $urandom;
      overflow = 1'($urandom);
      carryout = 1'($urandom);
      zero     = 1'($urandom);
      press(4'(1 << idx), s, 10);
      case (idx)
        0: begin m_a = (m_a << 4) | {28'd0, s}; m_led = s; m_show = 1'b0; end
        1: begin m_b = (m_b << 4) | {28'd0, s}; m_led = s; m_show = 1'b0; end
        2: begin m_cmd = s[2:0]; m_led = {1'b0, s[2:0]}; m_show = 1'b0; end
        default: begin
          if (!m_show) begin
            m_snap  = result;
            m_flags = {overflow, carryout, zero};
            m_page  = 0;
            m_show  = 1'b1;
          end else begin
            m_page = (m_page + 1) % 9;
          end
          m_led = model_disp(m_snap, m_flags, m_page);
        end
      endcase
      check_all($sformatf("rand%0d", it), m_a, m_b, m_cmd, m_led, m_show);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
